// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the MIPS-32 boot/run/dump controller.
package mips_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_CLR,
        ST_RUN,
        ST_DUMP,
        ST_DONE
    } boot_state_e;

    localparam logic       LD_SEL_IMEM = 1'b0;
    localparam logic       LD_SEL_RF   = 1'b1;
    localparam logic [5:0] HALT_OPCODE = 6'h3f;

    // The load port is open only while the core is parked.
    function automatic logic ld_open(input boot_state_e s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/mips_boot_dump.sv
// Register-window dump streamer: walks indices 0..DUMP_N-1 over the
// combinational register read port and presents each word on a valid/ready stream.
module mips_boot_dump
    import mips_boot_pkg::*;
#(
    parameter int DW     = 32,
    parameter int RF_AW  = 5,
    parameter int DUMP_N = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             active_i,
    input  logic             dump_ready_i,
    input  logic [DW-1:0]    rf_rdata_i,
    output logic [RF_AW-1:0] rf_raddr_o,
    output logic             dump_valid_o,
    output logic [RF_AW-1:0] dump_idx_o,
    output logic [DW-1:0]    dump_data_o,
    output logic             last_hs_o
);

    localparam int            PW        = RF_AW + 1;
    localparam logic [PW-1:0] NUM_WORDS = PW'(DUMP_N);
    localparam logic [PW-1:0] LAST_IDX  = PW'(DUMP_N - 1);

    logic [PW-1:0]    ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic [RF_AW-1:0] idx_q, idx_d;
    logic [DW-1:0]    data_q, data_d;
    logic             handshake;
    logic             load;

    // ptr_q is the next index to fetch; a new word is captured whenever the
    // output slot is empty or being drained this cycle.
    assign handshake = valid_q && dump_ready_i;
    assign load      = active_i && (ptr_q != NUM_WORDS) && (!valid_q || dump_ready_i);

    always_comb begin
        ptr_d   = ptr_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        data_d  = data_q;
        if (!active_i) begin
            ptr_d   = '0;
            valid_d = 1'b0;
        end else if (load) begin
            ptr_d   = ptr_q + 1'b1;
            valid_d = 1'b1;
            idx_d   = ptr_q[RF_AW-1:0];
            data_d  = rf_rdata_i;
        end else if (handshake) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    assign rf_raddr_o   = ptr_q[RF_AW-1:0];
    assign dump_valid_o = valid_q;
    assign dump_idx_o   = idx_q;
    assign dump_data_o  = data_q;
    assign last_hs_o    = handshake && ({1'b0, idx_q} == LAST_IDX);

endmodule

// File: rtl/mips_boot_ctrl.sv
// Boot, run and dump controller for the pipelined MIPS-32 core.
// Optional feature macro: MIPS_BOOT_REGINIT_EN (seeds Rk = k before every run).
module mips_boot_ctrl
    import mips_boot_pkg::*;
#(
    parameter int DW         = 32,
    parameter int AW         = 10,
    parameter int RF_AW      = 5,
    parameter int DUMP_N     = 6,
    parameter int CW         = 16,
    parameter int MAX_CYCLES = 1000
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic             ld_sel,
    input  logic [AW-1:0]    ld_addr,
    input  logic [DW-1:0]    ld_data,
    input  logic             start,
    output logic             imem_we,
    output logic [AW-1:0]    imem_addr,
    output logic [DW-1:0]    imem_wdata,
    output logic             rf_we,
    output logic [RF_AW-1:0] rf_addr,
    output logic [DW-1:0]    rf_wdata,
    output logic [RF_AW-1:0] rf_raddr,
    input  logic [DW-1:0]    rf_rdata,
    output logic             core_pc_clr,
    output logic             core_run,
    input  logic             core_halted,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [RF_AW-1:0] dump_idx,
    output logic [DW-1:0]    dump_data,
    output logic             busy,
    output logic             timeout,
    output logic [CW-1:0]    cycles
);

    boot_state_e   state_q, state_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic          timeout_q, timeout_d;
    logic          imem_we_q, rf_ld_we_q;
    logic [AW-1:0] ld_addr_q;
    logic [DW-1:0] ld_data_q;
    logic          accept;
    logic          dump_last_hs;
`ifdef MIPS_BOOT_REGINIT_EN
    logic [RF_AW-1:0] seed_q, seed_d;
`endif

    assign ld_ready = ld_open(state_q);
    assign accept   = ld_valid && ld_ready;

    always_comb begin
        state_d   = state_q;
        cycles_d  = cycles_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    cycles_d  = '0;
                    timeout_d = 1'b0;
`ifdef MIPS_BOOT_REGINIT_EN
                    state_d   = ST_SEED;
`else
                    state_d   = ST_CLR;
`endif
                end
            end
`ifdef MIPS_BOOT_REGINIT_EN
            ST_SEED: if (seed_q == '1) state_d = ST_CLR;
`endif
            ST_CLR:  state_d = ST_RUN;
            ST_RUN: begin
                if (cycles_q != '1) cycles_d = cycles_q + 1'b1;
                // A halt seen in the same cycle as the watchdog limit is a clean halt.
                if (core_halted) begin
                    state_d = ST_DUMP;
                end else if (cycles_d >= CW'(MAX_CYCLES)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DUMP;
                end
            end
            ST_DUMP: if (dump_last_hs) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef MIPS_BOOT_REGINIT_EN
    assign seed_d = (state_q == ST_SEED) ? seed_q + 1'b1 : '0;
`endif

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cycles_q   <= '0;
            timeout_q  <= 1'b0;
            imem_we_q  <= 1'b0;
            rf_ld_we_q <= 1'b0;
            ld_addr_q  <= '0;
            ld_data_q  <= '0;
`ifdef MIPS_BOOT_REGINIT_EN
            seed_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cycles_q   <= cycles_d;
            timeout_q  <= timeout_d;
            imem_we_q  <= accept && (ld_sel == LD_SEL_IMEM);
            rf_ld_we_q <= accept && (ld_sel == LD_SEL_RF);
            if (accept) begin
                ld_addr_q <= ld_addr;
                ld_data_q <= ld_data;
            end
`ifdef MIPS_BOOT_REGINIT_EN
            seed_q     <= seed_d;
`endif
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = ld_addr_q;
    assign imem_wdata = ld_data_q;

    always_comb begin
        rf_we    = rf_ld_we_q;
        rf_addr  = ld_addr_q[RF_AW-1:0];
        rf_wdata = ld_data_q;
`ifdef MIPS_BOOT_REGINIT_EN
        if (state_q == ST_SEED) begin
            rf_we    = 1'b1;
            rf_addr  = seed_q;
            rf_wdata = DW'(seed_q);
        end
`endif
    end

    assign core_pc_clr = (state_q == ST_CLR);
    assign core_run    = (state_q == ST_RUN);
    assign busy        = !ld_open(state_q);
    assign timeout     = timeout_q;
    assign cycles      = cycles_q;

    mips_boot_dump #(
        .DW     (DW),
        .RF_AW  (RF_AW),
        .DUMP_N (DUMP_N)
    ) u_dump (
        .clk_i        (clk1),
        .rst_i        (rst),
        .active_i     (state_q == ST_DUMP),
        .dump_ready_i (dump_ready),
        .rf_rdata_i   (rf_rdata),
        .rf_raddr_o   (rf_raddr),
        .dump_valid_o (dump_valid),
        .dump_idx_o   (dump_idx),
        .dump_data_o  (dump_data),
        .last_hs_o    (dump_last_hs)
    );

endmodule
